// File: rtl/step_clock_gen_pkg.sv
// Shared constants and types for the step clock generator.
// Modes, FSM states and phase-counter sizing.
package step_clock_gen_pkg;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_FREE   = 2'd1;
  localparam logic [1:0] MODE_BURST  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  // Bits needed to hold max(pulse_w, 2^per_w - 1).
  function automatic int cnt_width(
    input int pulse_w,
    input int per_w
  );
    longint mx;
    int     w;
    mx = (longint'(1) << per_w) - 1;
    if (longint'(pulse_w) > mx)
      mx = longint'(pulse_w);
    w = 1;
    while ((longint'(1) << w) <= mx)
      w++;
    return w;
  endfunction

endpackage

// File: rtl/step_clock_gen_debouncer.sv
// Button synchroniser, debouncer and rising-edge trigger.
// Ports: clk, reset, button (raw) -> trig (1-cycle pulse).
module button_debouncer #(
  parameter int DEBOUNCE = 5000
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic trig
);

  localparam int DW = $clog2(DEBOUNCE + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [DW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      trig    <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= button;
      sync2   <= sync1;
      level_d <= level;
      trig    <= level & ~level_d;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/step_clock_gen.sv
// Step clock generator: single, free-run and burst stepping.
// Ports: button/mode/period/burst_len/clear_ticks in;
//        step_clk, step_strobe, ticks, busy, running out.
module step_clock_gen
  import step_clock_gen_pkg::*;
#(
  parameter int DEBOUNCE = 5000,
  parameter int PULSE_W  = 5000,
  parameter int PER_W    = 16,
  parameter int BURST_W  = 8,
  parameter int TICK_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               button,
  input  logic [1:0]         mode,
  input  logic [PER_W-1:0]   period,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               clear_ticks,
  output logic               step_clk,
  output logic               step_strobe,
  output logic [TICK_W-1:0]  ticks,
  output logic               busy,
  output logic               running
);

  localparam int CW = cnt_width(PULSE_W, PER_W);
  localparam logic [CW-1:0] PW_C = CW'(PULSE_W);

  logic trig;

  button_debouncer #(
    .DEBOUNCE(DEBOUNCE)
  ) u_deb (
    .clk   (clk),
    .reset (reset),
    .button(button),
    .trig  (trig)
  );

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      low_q, low_d;
  logic [1:0]         mode_q, mode_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               run_q, run_d;
  logic               stop_q, stop_d;
  logic               strb_q, strb_d;
  logic [TICK_W-1:0]  ticks_q;
  logic [CW-1:0]      per_ext;
  logic [CW-1:0]      long_low;

  assign per_ext  = CW'(period);
  // Free-run/burst low phase never shorter than the high phase.
  assign long_low = (per_ext > PW_C) ? per_ext : PW_C;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    low_d   = low_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    run_d   = run_q;
    stop_d  = stop_q;
    strb_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (trig) begin
          unique case (1'b1)
            (mode == MODE_FREE): begin
              mode_d  = MODE_FREE;
              low_d   = long_low;
              run_d   = 1'b1;
              stop_d  = 1'b0;
              state_d = ST_HIGH;
              strb_d  = 1'b1;
            end
            (mode == MODE_BURST): begin
              if (burst_len != '0) begin
                mode_d  = MODE_BURST;
                low_d   = long_low;
                rem_d   = burst_len;
                state_d = ST_HIGH;
                strb_d  = 1'b1;
              end
            end
            default: begin
              mode_d  = MODE_SINGLE;
              low_d   = PW_C;
              state_d = ST_HIGH;
              strb_d  = 1'b1;
            end
          endcase
        end
      end
      ST_HIGH: begin
        if (trig && mode_q == MODE_FREE)
          stop_d = 1'b1;
        if (cnt_q == PW_C - 1'b1) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LOW: begin
        if (trig && mode_q == MODE_FREE)
          stop_d = 1'b1;
        if (cnt_q == low_q - 1'b1) begin
          cnt_d = '0;
          unique case (1'b1)
            (mode_q == MODE_FREE): begin
              // A stop press landing on the last low cycle still stops.
              if (stop_q || trig) begin
                state_d = ST_IDLE;
                run_d   = 1'b0;
                stop_d  = 1'b0;
              end else begin
                state_d = ST_HIGH;
                strb_d  = 1'b1;
              end
            end
            (mode_q == MODE_BURST): begin
              rem_d = rem_q - 1'b1;
              if (rem_q == BURST_W'(1)) begin
                state_d = ST_IDLE;
              end else begin
                state_d = ST_HIGH;
                strb_d  = 1'b1;
              end
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      low_q   <= '0;
      mode_q  <= MODE_SINGLE;
      rem_q   <= '0;
      run_q   <= 1'b0;
      stop_q  <= 1'b0;
      strb_q  <= 1'b0;
      ticks_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      low_q   <= low_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      run_q   <= run_d;
      stop_q  <= stop_d;
      strb_q  <= strb_d;
      // Clear beats the increment from a coincident strobe.
      if (clear_ticks)
        ticks_q <= '0;
      else if (strb_q)
        ticks_q <= ticks_q + 1'b1;
    end
  end

  assign step_clk    = (state_q == ST_HIGH);
  assign step_strobe = strb_q;
  assign ticks       = ticks_q;
  assign busy        = (state_q != ST_IDLE);
  assign running     = run_q;

endmodule

// File: doc/step_clock_gen.md
Name: step_clock_gen

Overview:
- Parametrised manual/automatic step-clock generator that drives the CPU's stepping clock from a raw push-button.
- Synchronises and debounces the button, then issues step pulses in three modes: single-step, free-run with a programmable period, or a burst of N steps.
- Also maintains a wrapping step counter for the display.
- Sits between the board button and the CPU clock input; one instance per board.

Parameters:
- DEBOUNCE, 5000: consecutive stable cycles required to accept a button level change (>=1).
- PULSE_W, 5000: step_clk high time in clk cycles (>=1).
- PER_W, 16: width of the period input.
- BURST_W, 8: width of the burst_len input.
- TICK_W, 8: width of the step counter.

Ports:
- clk  input  1  system clock; the single clock of the block.
- reset  input  1  asynchronous, active-high reset.
- button  input  1  raw, asynchronous push-button.
- mode  input  2  0=single, 1=free-run, 2=burst, 3=reserved (behaves as single).
- period  input  PER_W  free-run/burst low-phase length in cycles.
- burst_len  input  BURST_W  number of steps per burst.
- clear_ticks  input  1  synchronous clear of ticks.
- step_clk  output  1  generated step clock.
- step_strobe  output  1  one-cycle pulse coincident with each step_clk rising edge.
- ticks  output  TICK_W  count of step_clk rising edges, wraps.
- busy  output  1  high whenever FSM is not IDLE.
- running  output  1  free-run mode active.

Behaviour:
- Reset (asynchronous, active-high, takes effect mid-pulse):
  - step_clk=0, step_strobe=0, ticks=0, busy=0, running=0.
  - Debounced level=0, synchroniser flops=0, FSM=IDLE.
- Input conditioning:
  - Two-flop synchroniser on button.
  - The debounced level flips once the synchronised value has differed from it for DEBOUNCE consecutive cycles; any agreeing cycle zeroes the counter.
  - trig is a registered one-cycle pulse on each rising edge of the debounced level. Falling edges produce nothing.
- Latency: counting the first edge that samples button=1 as edge 1, with the button held stable, step_clk rises on edge DEBOUNCE+4.
- Pulse shape:
  - HIGH phase lasts exactly PULSE_W cycles.
  - LOW phase lasts L = max(period, PULSE_W) cycles in free-run and burst, and L = PULSE_W in single.
  - A pulse, once started, is never truncated except by reset.
- FSM states:
  - IDLE
    - trig in single: go to HIGH.
    - trig in free-run: set running=1, go to HIGH.
    - trig in burst with burst_len!=0: load remaining=burst_len, go to HIGH.
    - trig in burst with burst_len=0: ignored.
    - mode, period and burst_len are sampled only here; changes while busy take effect at the next IDLE.
  - HIGH: step_clk=1. After PULSE_W cycles go to LOW.
  - LOW: step_clk=0. After L cycles:
    - single: go to IDLE.
    - burst: decrement remaining; go to IDLE when it reaches 0, otherwise go to HIGH.
    - free-run: go to IDLE if stop_req is set (clear running and stop_req), otherwise go to HIGH.
- Triggers while busy:
  - trig in single or burst mode is dropped. It is not queued.
  - trig in free-run while running sets stop_req; the current pulse and its LOW phase finish normally.
- Step counting:
  - step_strobe is asserted for exactly the cycle in which HIGH is entered.
  - ticks increments by 1 on that cycle and wraps from all-ones to 0.
  - If clear_ticks and step_strobe occur in the same cycle, ticks becomes 0 (clear wins).
- Widths: phase counters are sized to hold max(PULSE_W, 2^PER_W-1); period=0 is legal and yields L=PULSE_W.

Decomposition:
- Shared package:
  - Mode constants MODE_SINGLE=2'd0, MODE_FREE=2'd1, MODE_BURST=2'd2.
  - FSM state encodings ST_IDLE, ST_HIGH, ST_LOW.
- Sub-module button_debouncer (parameter DEBOUNCE): contains the synchroniser, the debounce counter and the rising-edge trig output. It is reused for other board buttons.
- Phase counter and FSM remain in step_clock_gen.

Test Plan:
- DEBOUNCE=4, PULSE_W=3, single mode; button held high from edge 1 -> step_clk rises on edge 8 and stays high 3 cycles, then low; ticks=1, step_strobe high for exactly 1 cycle.
- Bounce: button toggles every 2 cycles for 20 cycles, then settles high -> exactly one pulse; a second press during the HIGH/LOW phases is dropped and ticks stays 1.
- Burst: burst_len=3, period=5, PULSE_W=3 -> 3 pulses, each high 3 and low 5 cycles; busy falls after the 3rd low phase; ticks=3. Also burst_len=0 -> no pulse, busy stays 0.
- Free-run: period=2 (< PULSE_W=3) -> low phase is 3 cycles; a press after 4 pulses stops the block after the current pulse completes; running=0, ticks=4 or 5 depending on the phase at the press, with no truncated pulse.
- Wrap and clear: TICK_W=8, 256 single steps -> ticks=0; assert clear_ticks in the same cycle as step_strobe -> ticks=0.
- Async reset asserted mid-HIGH, between clock edges -> step_clk, busy and ticks go to 0 immediately; after release the next press behaves as in the first test.
